// File: rtl/mem_rd_arbiter.sv
// rtl/mem_rd_arbiter.sv - two-master AXI-lite read arbiter, one outstanding read, starvation guard for master 0
// Optional ARB_PERF_CNT_EN adds 64-bit grant/conflict counters.
module mem_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  input  logic [ADDR_W-1:0] m0_araddr,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [ADDR_W-1:0] m1_araddr,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  input  logic              m1_rready,
  output logic              s_arvalid,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  output logic              s_rready
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [63:0]       perf_m0_grants,
  output logic [63:0]       perf_m1_grants,
  output logic [63:0]       perf_conflicts
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_nxt;
  logic              grant;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  starve_cnt;

  logic both_req, any_req, win_m1, accept, starved;

  assign both_req = m0_arvalid & m1_arvalid;
  assign any_req  = m0_arvalid | m1_arvalid;
  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
  // m1 (load/store) is preferred unless fetch has lost STARVE_MAX times in a row
  assign win_m1   = m1_arvalid & (~m0_arvalid | ~starved);
  assign accept   = (state == IDLE) & any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      addr_q     <= '0;
      starve_cnt <= '0;
    end else if (accept) begin
      grant  <= win_m1;
      addr_q <= win_m1 ? m1_araddr : m0_araddr;
      if (!win_m1) begin
        starve_cnt <= '0;
      end else if (both_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (s_arready) state_nxt = DATA;
      DATA:    if (s_rvalid && s_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = 2'b00;
    m1_rresp   = 2'b00;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    case (state)
      IDLE: begin
        m0_arready = m0_arvalid & ~win_m1;
        m1_arready = win_m1;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        s_araddr  = addr_q;
      end
      DATA: begin
        if (grant) begin
          s_rready  = m1_rready;
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          s_rready  = m0_rready;
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
      end
      default: ;
    endcase
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_m0_grants <= '0;
      perf_m1_grants <= '0;
      perf_conflicts <= '0;
    end else if (accept) begin
      if (win_m1) perf_m1_grants <= perf_m1_grants + 64'd1;
      else        perf_m0_grants <= perf_m0_grants + 64'd1;
      if (both_req) perf_conflicts <= perf_conflicts + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb/tb_mem_rd_arbiter.sv - scoreboard bench for mem_rd_arbiter with a behavioural memory and two master drivers
module tb_mem_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [AW-1:0] m0_araddr;
  logic [DW-1:0] m0_rdata;
  logic [1:0]    m0_rresp;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [AW-1:0] m1_araddr;
  logic [DW-1:0] m1_rdata;
  logic [1:0]    m1_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AW-1:0] s_araddr;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
`ifdef ARB_PERF_CNT_EN
  logic [63:0] perf_m0_grants, perf_m1_grants, perf_conflicts;
`endif

  mem_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready)
`ifdef ARB_PERF_CNT_EN
    , .perf_m0_grants(perf_m0_grants), .perf_m1_grants(perf_m1_grants), .perf_conflicts(perf_conflicts)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 64'h0000_0013_0000_0297 : {~a, a};
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    return a[13:12];
  endfunction

  typedef struct {
    bit          m;
    logic [31:0] addr;
  } exp_t;

  exp_t        exp_r_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] m0_q[$], m1_q[$];
  int          m0_stall = 0, m1_stall = 0;
  int          ar_delay = 0, r_delay = 0;
  bit          have_req = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] req_addr = '0, hs_addr = '0;
  int          ar_cnt = 0, r_cnt = 0;
  int          cyc = 0, t_acc = 0, t_ar = 0, t_r = 0, bp_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic sample_r(input bit m, input logic rv, input logic rr,
                          input logic [63:0] rd, input logic [1:0] rs);
    exp_t e;
    if (rv && !rr) begin
      check("s_rready_bp", 64'(s_rready), 64'd0);
      bp_cycles++;
    end
    if (rv && rr) begin
      if (exp_r_q.size() == 0) begin
        check("r_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_r_q.pop_front();
        check("r_master", 64'(m), 64'(e.m));
        check("rdata", rd, mem_data(e.addr));
        check("rresp", 64'(rs), 64'(mem_resp(e.addr)));
        t_r = cyc;
      end
    end
  endtask

  // Drivers and memory update on the falling edge; handshakes are sampled 1ns later.
  initial begin
    m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
    m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_req = 0; ar_hs = 0; r_hs = 0; ar_cnt = 0; r_cnt = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
      end else begin
        if (ar_hs) begin have_req = 1; req_addr = hs_addr; r_cnt = 0; end
        if (r_hs) have_req = 0;
        s_arready = 0;
        if (s_arvalid && !have_req) begin
          s_arready = (ar_cnt >= ar_delay);
          ar_cnt++;
        end else begin
          ar_cnt = 0;
        end
        s_rvalid = have_req && (r_cnt >= r_delay);
        if (have_req) r_cnt++;
        s_rdata = s_rvalid ? mem_data(req_addr) : '0;
        s_rresp = s_rvalid ? mem_resp(req_addr) : 2'b00;
      end
      m0_arvalid = (m0_q.size() > 0);
      m0_araddr  = m0_arvalid ? m0_q[0] : '0;
      m1_arvalid = (m1_q.size() > 0);
      m1_araddr  = m1_arvalid ? m1_q[0] : '0;
      m0_rready  = (m0_stall == 0);
      m1_rready  = (m1_stall == 0);
      #1;
      ar_hs   = s_arvalid & s_arready;
      hs_addr = s_araddr;
      r_hs    = s_rvalid & s_rready;
      if (!rst) begin
        if (s_arvalid) begin
          if (exp_ar_q.size() == 0) begin
            check("ar_unexpected", 64'd1, 64'd0);
          end else begin
            check("s_araddr", 64'(s_araddr), 64'(exp_ar_q[0]));
            if (ar_hs) begin void'(exp_ar_q.pop_front()); t_ar = cyc; end
          end
        end
        if (m0_arvalid && m1_arvalid) check("arready_excl", 64'(m0_arready & m1_arready), 64'd0);
        if (m0_arvalid && m0_arready) begin void'(m0_q.pop_front()); t_acc = cyc; end
        if (m1_arvalid && m1_arready) begin void'(m1_q.pop_front()); t_acc = cyc; end
        if (m0_rvalid || m1_rvalid) check("rvalid_excl", 64'(m0_rvalid & m1_rvalid), 64'd0);
        sample_r(1'b0, m0_rvalid, m0_rready, m0_rdata, m0_rresp);
        sample_r(1'b1, m1_rvalid, m1_rready, m1_rdata, m1_rresp);
        if (m0_rvalid && !m0_rready && m0_stall > 0) m0_stall--;
        if (m1_rvalid && !m1_rready && m1_stall > 0) m1_stall--;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic req(input bit m, input logic [31:0] a);
    if (m) m1_q.push_back(a); else m0_q.push_back(a);
  endtask

  task automatic expect_rd(input bit m, input logic [31:0] a);
    exp_t e;
    e.m = m; e.addr = a;
    exp_ar_q.push_back(a);
    exp_r_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((m0_q.size() + m1_q.size() + exp_r_q.size()) != 0 && k < 300) begin
      tick(1);
      k++;
    end
    check({"drain_", tag}, 64'(m0_q.size() + m1_q.size() + exp_r_q.size()), 64'd0);
    tick(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, 64'({m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready}), 64'd0);
    check({tag, "_araddr"}, 64'(s_araddr), 64'd0);
    check({tag, "_m0_rdata"}, m0_rdata, 64'd0);
    check({tag, "_m1_rdata"}, m1_rdata, 64'd0);
    check({tag, "_rresp"}, 64'({m0_rresp, m1_rresp}), 64'd0);
  endtask

`ifdef ARB_PERF_CNT_EN
  logic [63:0] p0, p1, pc;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    tick(2);
    check_outputs_zero("reset");
    rst = 0;
    tick(1);

    // single fetch, zero-wait memory
    req(0, 32'h8000_0000);
    expect_rd(0, 32'h8000_0000);
    wait_done("single");
    check("lat_ar", 64'(t_ar - t_acc), 64'd1);
    check("lat_r", 64'(t_r - t_acc), 64'd2);

    // simultaneous requests: load/store first
    req(0, 32'h8000_0004);
    req(1, 32'h8000_1000);
    expect_rd(1, 32'h8000_1000);
    expect_rd(0, 32'h8000_0004);
    wait_done("conflict");

    // starvation: m1 wins four times, then m0 is forced through
    for (int i = 0; i < 8; i++) req(1, 32'h8000_2000 + 32'(4 * i));
    for (int i = 0; i < 2; i++) req(0, 32'h8000_0100 + 32'(4 * i));
    for (int i = 0; i < 4; i++) expect_rd(1, 32'h8000_2000 + 32'(4 * i));
    expect_rd(0, 32'h8000_0100);
    for (int i = 4; i < 8; i++) expect_rd(1, 32'h8000_2000 + 32'(4 * i));
    expect_rd(0, 32'h8000_0104);
    wait_done("starve");

    // 4 m1 grants and 4 conflicts, then a lone m0 grant
`ifdef ARB_PERF_CNT_EN
    p0 = perf_m0_grants; p1 = perf_m1_grants; pc = perf_conflicts;
`endif
    for (int i = 0; i < 4; i++) req(1, 32'h8000_4000 + 32'(4 * i));
    req(0, 32'h8000_0180);
    for (int i = 0; i < 4; i++) expect_rd(1, 32'h8000_4000 + 32'(4 * i));
    expect_rd(0, 32'h8000_0180);
    wait_done("perf");
`ifdef ARB_PERF_CNT_EN
    check("perf_m1", perf_m1_grants - p1, 64'd4);
    check("perf_m0", perf_m0_grants - p0, 64'd1);
    check("perf_conf", perf_conflicts - pc, 64'd4);
`endif

    // backpressure on address and data; m0 must wait behind m1
    ar_delay = 3;
    bp_cycles = 0;
    m1_stall = 2;
    req(1, 32'h8000_3000);
    expect_rd(1, 32'h8000_3000);
    tick(3);
    req(0, 32'h8000_0200);
    expect_rd(0, 32'h8000_0200);
    wait_done("backpressure");
    check("bp_cycles", 64'(bp_cycles), 64'd2);
    ar_delay = 0;

    // reset while waiting for data
    r_delay = 20;
    req(0, 32'h8000_0300);
    exp_ar_q.push_back(32'h8000_0300);
    for (int k = 0; k < 20 && exp_ar_q.size() != 0; k++) tick(1);
    check("pre_rst_addr", 64'(exp_ar_q.size()), 64'd0);
    tick(1);
    rst = 1;
    exp_r_q.delete();
    m0_q.delete();
    tick(1);
    check_outputs_zero("rst_mid");
    rst = 0;
    r_delay = 0;
    tick(1);
    req(0, 32'h8000_0400);
    expect_rd(0, 32'h8000_0400);
    wait_done("after_rst");
    check("lat_r_after_rst", 64'(t_r - t_acc), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
